// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the key schedule, round datapath and stream wrapper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_SCHED_W = 1408;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CTR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_START,
    ST_KEY_WAIT,
    ST_READY,
    ST_CRYPT_START,
    ST_CRYPT_WAIT,
    ST_OUT_HOLD
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] r;
    y = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] m0, m1, m2, m3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        m0 = a0; m1 = a1; m2 = a2; m3 = a3;
      end else begin
        m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      o[127-32*c -: 32] = {m0, m1, m2, m3};
    end
    return o ^ rk;
  endfunction

endpackage

// File: rtl/aes_crypt.sv
// AES-128 encryption, one round per cycle from a cached schedule.
// dout is valid while done pulses and holds until the next trigger.
module aes_crypt
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trigger,
  input  logic [AES_SCHED_W-1:0] sched,
  input  logic [127:0]           din,
  output logic                   done,
  output logic [127:0]           dout
);

  logic [127:0] st_q, st_d, rk;
  logic [3:0]   rnd_q, rnd_d;
  logic         run_q, run_d;
  logic         done_q, done_d;

  always_comb begin
    rk = '0;
    for (int r = 1; r <= 10; r++)
      if (rnd_q == 4'(r)) rk = sched[r*128 +: 128];
    st_d   = st_q;
    rnd_d  = rnd_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (trigger) begin
      st_d  = din ^ sched[127:0];
      rnd_d = 4'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      st_d  = aes_round(st_q, rk, rnd_q == 4'd10);
      rnd_d = rnd_q + 4'd1;
      if (rnd_q == 4'd10) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      rnd_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign dout = st_q;

endmodule

// File: rtl/aes_ctr_inc.sv
// Partial-width counter incrementer for CTR mode.
// Only the low W bits roll over; the rest pass through.
module aes_ctr_inc #(
  parameter int W = 32
) (
  input  logic [127:0] ctr_i,
  output logic [127:0] ctr_o
);

  if (W >= 128) begin : g_full
    assign ctr_o = ctr_i + 128'd1;
  end else begin : g_part
    assign ctr_o = {ctr_i[127:W],
                    ctr_i[W-1:0] + {{(W-1){1'b0}}, 1'b1}};
  end

endmodule

// File: rtl/aes_key.sv
// AES-128 key expansion, one round key per cycle after trigger.
// Round key r ends up at sched[r*128 +: 128]; done pulses when complete.
module aes_key
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trigger,
  input  logic [127:0]           key,
  output logic                   done,
  output logic [AES_SCHED_W-1:0] sched
);

  logic [AES_SCHED_W-1:0] sched_q, sched_d;
  logic [3:0]             rnd_q, rnd_d;
  logic [7:0]             rcon_q, rcon_d;
  logic                   run_q, run_d;
  logic                   done_q, done_d;
  logic [31:0]            w0, w1, w2, w3, t;
  logic [31:0]            n0, n1, n2, n3;

  // Newest round key always sits in the top slot and shifts down.
  always_comb begin
    w0 = sched_q[1407:1376];
    w1 = sched_q[1375:1344];
    w2 = sched_q[1343:1312];
    w3 = sched_q[1311:1280];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    sched_d = sched_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (trigger) begin
      sched_d = {key, sched_q[1407:128]};
      rnd_d   = 4'd10;
      rcon_d  = 8'h01;
      run_d   = 1'b1;
    end else if (run_q) begin
      sched_d = {n0, n1, n2, n3, sched_q[1407:128]};
      rcon_d  = xtime(rcon_q);
      rnd_d   = rnd_q - 4'd1;
      if (rnd_q == 4'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_q <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sched_q <= sched_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign done  = done_q;
  assign sched = sched_q;

endmodule

// File: rtl/aes_stream.sv
// Streaming AES-128 engine: cached key schedule, ECB and CTR modes,
// valid/ready handshakes on input and output blocks.
module aes_stream
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 32,
  parameter int CTR_EN    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic         key_load,
  output logic         key_ack,
  output logic         key_valid,
  input  logic         mode,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [31:0]  blk_count
);

  state_t       state_q, state_d;
  logic         key_ack_q, key_ack_d;
  logic         key_valid_q, key_valid_d;
  logic         first_q, first_d;
  logic         mode_q, mode_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic [127:0] ctr_q, ctr_d;
  logic [127:0] out_q, out_d;
  logic [31:0]  cnt_q, cnt_d;

  logic                   k_trig, k_done;
  logic                   c_trig, c_done;
  logic [AES_SCHED_W-1:0] sched;
  logic [127:0]           crypt_din, crypt_dout, ctr_nx;

  assign crypt_din = (mode_q == MODE_CTR) ? ctr_q : data_q;

  aes_key u_key (
    .clk     (clk),
    .rst_n   (reset),
    .trigger (k_trig),
    .key     (key_q),
    .done    (k_done),
    .sched   (sched)
  );

  aes_crypt u_crypt (
    .clk     (clk),
    .rst_n   (reset),
    .trigger (c_trig),
    .sched   (sched),
    .din     (crypt_din),
    .done    (c_done),
    .dout    (crypt_dout)
  );

  aes_ctr_inc #(.W(CTR_WIDTH)) u_inc (
    .ctr_i (ctr_q),
    .ctr_o (ctr_nx)
  );

  always_comb begin
    state_d     = state_q;
    key_ack_d   = 1'b0;
    key_valid_d = key_valid_q;
    first_d     = 1'b0;
    mode_d      = mode_q;
    key_d       = key_q;
    data_d      = data_q;
    ctr_d       = ctr_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    k_trig      = 1'b0;
    c_trig      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if (key_load) begin
          key_ack_d   = 1'b1;
          key_valid_d = 1'b0;
          key_d       = key;
          ctr_d       = (CTR_EN != 0) ? iv : '0;
          cnt_d       = '0;
          state_d     = ST_KEY_START;
        end else if (state_q == ST_READY && in_valid) begin
          data_d  = in_data;
          mode_d  = (CTR_EN != 0) ? mode : MODE_ECB;
          state_d = ST_CRYPT_START;
        end
      end
      ST_KEY_START: begin
        k_trig  = 1'b1;
        first_d = 1'b1;
        state_d = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: begin
        if (!first_q && k_done) begin
          key_valid_d = 1'b1;
          state_d     = ST_READY;
        end
      end
      ST_CRYPT_START: begin
        c_trig  = 1'b1;
        first_d = 1'b1;
        state_d = ST_CRYPT_WAIT;
      end
      ST_CRYPT_WAIT: begin
        if (!first_q && c_done) begin
          out_d   = (mode_q == MODE_CTR) ? (crypt_dout ^ data_q)
                                         : crypt_dout;
          state_d = ST_OUT_HOLD;
        end
      end
      ST_OUT_HOLD: begin
        if (out_ready) begin
          cnt_d = cnt_q + 32'd1;
          if (CTR_EN != 0 && mode_q == MODE_CTR) ctr_d = ctr_nx;
          state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      key_ack_q   <= 1'b0;
      key_valid_q <= 1'b0;
      first_q     <= 1'b0;
      mode_q      <= MODE_ECB;
      key_q       <= '0;
      data_q      <= '0;
      ctr_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_ack_q   <= key_ack_d;
      key_valid_q <= key_valid_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      data_q      <= data_d;
      ctr_q       <= ctr_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign key_ack   = key_ack_q;
  assign key_valid = key_valid_q;
  assign in_ready  = (state_q == ST_READY);
  assign out_valid = (state_q == ST_OUT_HOLD);
  assign busy      = (state_q != ST_READY) && (state_q != ST_IDLE);
  assign out_data  = out_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_aes_stream.sv
// Directed bench for aes_stream: FIPS/SP800-38A vectors, backpressure,
// key priority, counter wrap (second instance, 8-bit counter) and reset.
module tb_aes_stream;

  localparam logic [127:0] KA  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IVB = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] T1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] E1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] E2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] E3  = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] IVW = 128'h00112233445566778899aabbccddaaff;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] key = '0;
  logic         key_load = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] iv = '0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         key_ack, key_valid, in_ready, out_valid, busy;
  logic [127:0] out_data;
  logic [31:0]  blk_count;
  logic         key_ack2, key_valid2, in_ready2, out_valid2, busy2;
  logic [127:0] out_data2;
  logic [31:0]  blk_count2;

  int checks = 0;
  int errors = 0;
  int acks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (key_ack) acks++;

  aes_stream dut (
    .clk(clk), .reset(reset), .key(key), .key_load(key_load),
    .key_ack(key_ack), .key_valid(key_valid), .mode(mode), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .blk_count(blk_count)
  );

  aes_stream #(.CTR_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .key(key), .key_load(key_load),
    .key_ack(key_ack2), .key_valid(key_valid2), .mode(mode), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .busy(busy2), .blk_count(blk_count2)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return in_ready;
      1:       return out_valid;
      2:       return key_valid;
      default: return key_ack;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int s);
    int n;
    n = 0;
    while (!sig(s) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (sig(s)) else begin
      errors++;
      $error("FAIL %s timeout obs=0 exp=1", tag);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] v);
    key = k;
    iv = v;
    key_load = 1'b1;
    wait_sig("key_ack", 3);
    key_load = 1'b0;
    chk1("ack_busy", busy, 1'b1);
    chk1("ack_kv", key_valid, 1'b0);
    chk32("ack_cnt", blk_count, 32'd0);
    @(posedge clk); #1;
    chk1("ack_pulse", key_ack, 1'b0);
    wait_sig("key_valid", 2);
    chk1("kv_ready", in_ready, 1'b1);
    chk1("kv_busy", busy, 1'b0);
  endtask

  task automatic send(input string tag, input logic [127:0] d,
                      input logic md, input logic chk_out,
                      input logic [127:0] exp, input int hold);
    logic [31:0] c0;
    c0 = blk_count;
    in_data = d;
    mode = md;
    in_valid = 1'b1;
    wait_sig({tag, "_in"}, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = ~d;
    chk1({tag, "_acc"}, in_ready, 1'b0);
    wait_sig({tag, "_out"}, 1);
    if (chk_out) chk128({tag, "_data"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk1({tag, "_hv"}, out_valid, 1'b1);
      chk1({tag, "_hr"}, in_ready, 1'b0);
      chk32({tag, "_hc"}, blk_count, c0);
      if (chk_out) chk128({tag, "_hd"}, out_data, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1({tag, "_ov0"}, out_valid, 1'b0);
    chk1({tag, "_rdy"}, in_ready, 1'b1);
    chk32({tag, "_cnt"}, blk_count, c0 + 32'd1);
  endtask

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ack", key_ack, 1'b0);
    chk1("rst_kv", key_valid, 1'b0);
    chk1("rst_rdy", in_ready, 1'b0);
    chk1("rst_ov", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk128("rst_out", out_data, 128'd0);
    chk32("rst_cnt", blk_count, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk1("idle_rdy", in_ready, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end
    in_valid = 1'b0;

    load_key(KA, 128'd0);
    send("ecb_kat", PA, 1'b0, 1'b1, CA, 0);
    chk32("ecb_cnt1", blk_count, 32'd1);
    send("bp", PA, 1'b0, 1'b1, CA, 10);
    chk32("bp_cnt", blk_count, 32'd2);
    @(posedge clk); #1;
    chk1("bp_once", out_valid, 1'b0);
    chk32("bp_cnt2", blk_count, 32'd2);

    load_key(KB, IVB);
    chk128("ctr_iv", dut.ctr_q, IVB);
    send("ctr_kat", P1, 1'b1, 1'b1, T1, 0);
    chk128("ctr_nx32", dut.ctr_q, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
    chk128("ctr_nx8", dut2.ctr_q, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe00);
    chk128("ctr_out8", out_data2, T1);

    a0 = acks;
    send("reuse1", P1, 1'b0, 1'b1, E1, 0);
    send("reuse2", P2, 1'b0, 1'b1, E2, 0);
    send("reuse3", P3, 1'b0, 1'b1, E3, 0);
    chk32("reuse_acks", acks, a0);
    chk32("reuse_cnt", blk_count, 32'd4);
    chk128("ecb_ctr", dut.ctr_q, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);

    key = KB;
    iv = IVW;
    key_load = 1'b1;
    in_data = P1;
    mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    chk1("pri_ack", key_ack, 1'b1);
    chk1("pri_kv", key_valid, 1'b0);
    chk32("pri_cnt", blk_count, 32'd0);
    chk1("pri_rdy", in_ready, 1'b0);
    chk128("pri_ctr", dut.ctr_q, IVW);
    wait_sig("pri_kv", 2);
    chk1("pri_rdy2", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("pri_acc", busy, 1'b1);
    wait_sig("pri_out", 1);
    chk128("pri_data", out_data, E1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk32("pri_cnt1", blk_count, 32'd1);

    send("wrap1", P1, 1'b1, 1'b0, 128'd0, 0);
    chk128("wrap1_8", dut2.ctr_q, 128'h00112233445566778899aabbccddaa00);
    chk128("wrap1_32", dut.ctr_q, 128'h00112233445566778899aabbccddab00);
    send("wrap2", P2, 1'b1, 1'b0, 128'd0, 0);
    chk128("wrap2_8", dut2.ctr_q, 128'h00112233445566778899aabbccddaa01);
    chk128("wrap2_32", dut.ctr_q, 128'h00112233445566778899aabbccddab01);

    in_data = PA;
    mode = 1'b1;
    in_valid = 1'b1;
    wait_sig("mid_in", 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("mid_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_busy0", busy, 1'b0);
    chk1("mid_kv", key_valid, 1'b0);
    chk1("mid_rdy", in_ready, 1'b0);
    chk1("mid_ov", out_valid, 1'b0);
    chk1("mid_ack", key_ack, 1'b0);
    chk128("mid_out", out_data, 128'd0);
    chk32("mid_cnt", blk_count, 32'd0);
    chk128("mid_ctr", dut.ctr_q, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk1("post_rdy", in_ready, 1'b0);
      chk1("post_ov", out_valid, 1'b0);
    end
    in_valid = 1'b0;
    load_key(KA, 128'd0);
    send("post_kat", PA, 1'b0, 1'b1, CA, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_stream.md
# aes_stream

Streaming AES-128 encryption engine that wraps the existing `aes_key` key-schedule and `aes_crypt` round blocks behind valid/ready handshakes. The key schedule is cached: it is expanded once per `key_load` and reused for any number of blocks. A parametrised counter (CTR) mode runs alongside ECB. It sits between a host/DMA front end and the existing AES datapath, and replaces one-shot trigger/done control for multi-block traffic.

## Interface
- `CTR_WIDTH`, default 32: low bits of the 128-bit counter that increment per block (range 8..128).
- `CTR_EN`, default 1: 0 removes CTR logic; `mode` is then ignored and the block runs ECB only.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `key` in 128: cipher key, sampled on an accepted `key_load`.
- `key_load` in 1: request key expansion.
- `key_ack` out 1: one-cycle pulse when `key_load` is accepted.
- `key_valid` out 1: a cached schedule is valid.
- `mode` in 1: 0 = ECB, 1 = CTR. Sampled per accepted input block.
- `iv` in 128: initial counter block, loaded into the counter on an accepted `key_load`.
- `in_valid` / `in_ready` in/out 1: input block handshake.
- `in_data` in 128: plaintext block.
- `out_valid` / `out_ready` out/in 1: output block handshake.
- `out_data` out 128: ciphertext block.
- `busy` out 1: high in every state except READY and IDLE.
- `blk_count` out 32: blocks emitted since the last key load; wraps modulo 2^32.

## Operation
- States: IDLE, KEY_START, KEY_WAIT, READY, CRYPT_START, CRYPT_WAIT, OUT_HOLD.
- **IDLE:** `key_valid`=0 and `in_ready`=0.
  - `key_load` → KEY_START, with `key_ack` pulsed.
- **KEY_START:** one-cycle `trigger` to `aes_key` → KEY_WAIT.
- **KEY_WAIT:** on `aes_key.done` → READY and `key_valid`=1. `done` is ignored in the first cycle after the trigger.
- **READY:** `in_ready`=1.
  - `key_load` has priority over a simultaneous `in_valid`. It clears `key_valid`, reloads the counter from `iv`, zeroes `blk_count`, and goes → KEY_START.
  - Otherwise, `in_valid` is accepted: `in_data` and `mode` are latched → CRYPT_START.
- **CRYPT_START:** one-cycle `trigger` to `aes_crypt` → CRYPT_WAIT.
  - Crypt input is `in_data` in ECB and the counter register in CTR.
- **CRYPT_WAIT:** on `aes_crypt.done` → OUT_HOLD. The same first-cycle rule as KEY_WAIT applies.
  - Result is registered: `out_data` = crypt output (ECB) or crypt output XOR latched plaintext (CTR).
- **OUT_HOLD:** `out_valid`=1. `out_data` is stable until `out_ready`.
  - On `out_valid & out_ready`: `blk_count`+1.
  - CTR only: the counter increments, then → READY.
- **Counter arithmetic:** bits [CTR_WIDTH-1:0] increment modulo 2^CTR_WIDTH. Bits [127:CTR_WIDTH] never change. All-ones wraps to zero with no flag. ECB blocks do not touch the counter.
- `key_load` outside READY/IDLE gets no `key_ack`. It must be held by the requester until acknowledged.
- Undefined state encoding → IDLE.
- Input changes while not in READY are ignored.

## Timing
- **Reset values:** state IDLE; `key_ack`, `key_valid`, `in_ready`, `out_valid`, `busy` = 0; `out_data`, counter, `blk_count` = 0; sub-block triggers = 0.
- **Reset mid-operation:** any in-flight block and the cached key are discarded. The first post-reset operation requires `key_load`.
- **Latency:** accept at edge T → CRYPT_START in cycle T+1 → `out_valid` asserts at T+2+Lc, where Lc is the `aes_crypt` done latency.
- **Key load:** `key_ack` at edge of acceptance; `key_valid` rises 2+Lk cycles later.
- **Handshake rules:** there is no combinational path from `out_ready` or `in_valid` to any output. `in_ready` is a registered function of state.
- **Throughput:** one block in flight. The next `in_ready` is the cycle after the output handshake.

## Structure
- A shared package `aes_pkg` holds:
  - state encoding;
  - `MODE_ECB`/`MODE_CTR` constants;
  - `AES_BLOCK_W`=128;
  - `AES_SCHED_W`=1408.
- One natural sub-module is `aes_ctr_inc`, a parametrised CTR_WIDTH partial incrementer. `aes_key` and `aes_crypt` are instantiated unchanged.

## Test plan
- **ECB known answer:** key 000102…0f, plaintext 00112233…ff → `out_data` 69c4e0d86a7b0430d8cdb78070b4c55a, `blk_count`=1.
- **CTR known answer:** key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1…feff, plaintext 6bc1bee22e409f96e93d7e117393172a → 874d6191b620e3261bef6864990db6ce. Counter afterwards is …fcfdff00.
- **Counter wrap:** CTR_WIDTH=8, iv 0x…aa_ff, 2 blocks → second counter 0x…aa_00 with upper bits unchanged.
- **Output backpressure:** `out_ready`=0 for 10 cycles → `out_data` stable, `in_ready`=0, no count change. Release → exactly one transfer.
- **Key reuse and priority:** 3 ECB blocks run with no extra key expansion. `key_load` and `in_valid` in the same READY cycle → key wins, `blk_count`=0, and the input is accepted only after `key_valid`.
- **Reset mid-operation:** `reset`=0 during CRYPT_WAIT → all outputs go to reset values immediately. `in_valid` afterwards sees `in_ready`=0 until a key is loaded.
